// File: rtl/cpu_run_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl_pkg
// Shared types for the CPU run/halt controller:
//   state_t  - controller state (BOOT, RUN, STEP, HALT)
//   cause_t  - reason the core was last halted, as seen on halt_cause
//   sel_width() - width of a channel-select bus for n channels (min 1 bit)
// -----------------------------------------------------------------------------
package cpu_run_ctrl_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      STEP = 2'd2,
      HALT = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE = 2'd0,
      CAUSE_HALT = 2'd1,
      CAUSE_BP   = 2'd2,
      CAUSE_STEP = 2'd3
   } cause_t;

   // A single channel still needs a 1-bit select port.
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cpu_run_ctrl_dbg_mux.sv
// -----------------------------------------------------------------------------
// dbg_mux
// Registered NUM_DBG:1 selector for the debug channels.
//   clk  - clock, rising edge
//   rst  - synchronous active-low reset, clears dout
//   sel  - channel select; values >= NUM_DBG select zero
//   din  - flattened channels, channel i is din[i*DATA_W +: DATA_W]
//   dout - selected channel, one cycle after sel/din
// -----------------------------------------------------------------------------
module dbg_mux
   import cpu_run_ctrl_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int NUM_DBG = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [sel_width(NUM_DBG)-1:0]   sel,
   input  logic [NUM_DBG*DATA_W-1:0]       din,
   output logic [DATA_W-1:0]               dout
);

   localparam int SEL_W = sel_width(NUM_DBG);

   logic [DATA_W-1:0] pick;

   // Compare against every legal index; an out-of-range select matches
   // nothing and falls through to the zero default.
   always_comb begin
      pick = '0;
      for (int i = 0; i < NUM_DBG; i++) begin
         if (sel == SEL_W'(i)) begin
            pick = din[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         dout <= '0;
      end else begin
         dout <= pick;
      end
   end

endmodule

// File: rtl/cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl
// Run/halt controller sitting between board control inputs and the CPU core.
// Gates the core through cpu_en and handles halt instructions, continue,
// N-cycle single-step and a PC breakpoint. Also keeps a saturating count of
// enabled cycles and a registered debug-channel mux.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-low reset
//   cont       - continue request (level, rising edge detected here)
//   step_req   - one-cycle step request pulse
//   step_count - enabled cycles per step (0 = request ignored)
//   bp_en      - breakpoint enable
//   bp_addr    - breakpoint PC
//   pc         - current PC from the core
//   halt_req   - core executed a halt instruction
//   dbg_sel    - debug channel select
//   dbg_in     - flattened debug channels
//   cpu_en     - core clock-enable
//   pwr        - high in every state except BOOT
//   halted     - high in HALT
//   halt_cause - 0 none, 1 halt instruction, 2 breakpoint, 3 step done
//   cycle_cnt  - saturating count of cycles with cpu_en=1
//   debug      - selected debug channel, registered
//
// Handshake: there is no valid/ready pair here. Requests (halt_req, step_req,
// cont edges) are sampled on a clock edge and take effect in the following
// cycle; every output is a register.
// -----------------------------------------------------------------------------
module cpu_run_ctrl
   import cpu_run_ctrl_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int NUM_DBG  = 4,
   parameter int STEP_W   = 16,
   parameter int CNT_W    = 32,
   parameter int BOOT_CYC = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            cont,
   input  logic                            step_req,
   input  logic [STEP_W-1:0]               step_count,
   input  logic                            bp_en,
   input  logic [ADDR_W-1:0]               bp_addr,
   input  logic [ADDR_W-1:0]               pc,
   input  logic                            halt_req,
   input  logic [sel_width(NUM_DBG)-1:0]   dbg_sel,
   input  logic [NUM_DBG*DATA_W-1:0]       dbg_in,
   output logic                            cpu_en,
   output logic                            pwr,
   output logic                            halted,
   output logic [1:0]                      halt_cause,
   output logic [CNT_W-1:0]                cycle_cnt,
   output logic [DATA_W-1:0]               debug
);

   localparam int                BOOT_W    = $clog2(BOOT_CYC + 1);
   localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYC - 1);

   state_t            state;
   cause_t            cause;
   cause_t            stop_cause;
   logic [BOOT_W-1:0] boot_cnt;
   logic              cont_q;
   logic [STEP_W-1:0] step_cnt;
   logic              bp_mask;

   logic cont_rise;
   logic bp_hit;
   logic step_ok;

   assign cont_rise  = cont & ~cont_q;
   // The mask suppresses the hit on the first enabled cycle after leaving
   // HALT, so the core can move past the PC it stopped on.
   assign bp_hit     = bp_en && (pc == bp_addr) && !bp_mask;
   assign step_ok    = step_req && (step_count != '0);
   assign halt_cause = cause;

   // Reason to stop while the core is enabled, highest priority first.
   // A step ends on the edge where the remaining count is 1, which gives
   // exactly step_count enabled cycles.
   always_comb begin
      stop_cause = CAUSE_NONE;
      if (halt_req) begin
         stop_cause = CAUSE_HALT;
      end else if (bp_hit) begin
         stop_cause = CAUSE_BP;
      end else if ((state == STEP) && (step_cnt == STEP_W'(1))) begin
         stop_cause = CAUSE_STEP;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= BOOT;
         cause     <= CAUSE_NONE;
         boot_cnt  <= '0;
         cont_q    <= 1'b0;
         step_cnt  <= '0;
         bp_mask   <= 1'b0;
         cpu_en    <= 1'b0;
         pwr       <= 1'b0;
         halted    <= 1'b0;
         cycle_cnt <= '0;
      end else begin
         cont_q <= cont;

         // cpu_en is the registered enable for the cycle now ending.
         if (cpu_en && (cycle_cnt != '1)) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
         end

         unique case (state)
            BOOT: begin
               if (boot_cnt == BOOT_LAST) begin
                  state  <= RUN;
                  cpu_en <= 1'b1;
                  pwr    <= 1'b1;
               end else begin
                  boot_cnt <= boot_cnt + BOOT_W'(1);
               end
            end

            RUN, STEP: begin
               bp_mask <= 1'b0;
               if (stop_cause != CAUSE_NONE) begin
                  state    <= HALT;
                  cpu_en   <= 1'b0;
                  halted   <= 1'b1;
                  cause    <= stop_cause;
                  step_cnt <= '0;
               end else if (state == STEP) begin
                  step_cnt <= step_cnt - STEP_W'(1);
               end
            end

            HALT: begin
               // halt_req is ignored here; continue beats a step request.
               if (cont_rise) begin
                  state   <= RUN;
                  cpu_en  <= 1'b1;
                  halted  <= 1'b0;
                  cause   <= CAUSE_NONE;
                  bp_mask <= 1'b1;
               end else if (step_ok) begin
                  state    <= STEP;
                  cpu_en   <= 1'b1;
                  halted   <= 1'b0;
                  step_cnt <= step_count;
                  bp_mask  <= 1'b1;
               end
            end

            default: begin
               state <= BOOT;
            end
         endcase
      end
   end

   dbg_mux #(
      .DATA_W  (DATA_W),
      .NUM_DBG (NUM_DBG)
   ) u_dbg_mux (
      .clk  (clk),
      .rst  (rst),
      .sel  (dbg_sel),
      .din  (dbg_in),
      .dout (debug)
   );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_run_ctrl
// Directed scenarios plus a randomized run against a behavioural model of the
// run/halt rules. A second instance with a 4-bit counter checks saturation.
// -----------------------------------------------------------------------------
module tb_cpu_run_ctrl;
   localparam int ADDR_W   = 32;
   localparam int DATA_W   = 32;
   localparam int NUM_DBG  = 3;
   localparam int STEP_W   = 16;
   localparam int CNT_W    = 32;
   localparam int BOOT_CYC = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                      rst;
   logic                      cont;
   logic                      step_req;
   logic [STEP_W-1:0]         step_count;
   logic                      bp_en;
   logic [ADDR_W-1:0]         bp_addr;
   logic [ADDR_W-1:0]         pc;
   logic                      halt_req;
   logic [1:0]                dbg_sel;
   logic [DATA_W-1:0]         ch [0:NUM_DBG-1];
   logic [NUM_DBG*DATA_W-1:0] dbg_in;

   logic              cpu_en, pwr, halted;
   logic [1:0]        halt_cause;
   logic [CNT_W-1:0]  cycle_cnt;
   logic [DATA_W-1:0] debug;

   logic              s_cpu_en, s_pwr, s_halted;
   logic [1:0]        s_halt_cause;
   logic [3:0]        s_cycle_cnt;
   logic [DATA_W-1:0] s_debug;

   assign dbg_in = {ch[2], ch[1], ch[0]};

   cpu_run_ctrl #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_DBG(NUM_DBG),
      .STEP_W(STEP_W), .CNT_W(CNT_W), .BOOT_CYC(BOOT_CYC)
   ) dut (
      .clk(clk), .rst(rst), .cont(cont), .step_req(step_req),
      .step_count(step_count), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
      .halt_req(halt_req), .dbg_sel(dbg_sel), .dbg_in(dbg_in),
      .cpu_en(cpu_en), .pwr(pwr), .halted(halted), .halt_cause(halt_cause),
      .cycle_cnt(cycle_cnt), .debug(debug)
   );

   cpu_run_ctrl #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_DBG(NUM_DBG),
      .STEP_W(STEP_W), .CNT_W(4), .BOOT_CYC(BOOT_CYC)
   ) dut_s (
      .clk(clk), .rst(rst), .cont(cont), .step_req(step_req),
      .step_count(step_count), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
      .halt_req(halt_req), .dbg_sel(dbg_sel), .dbg_in(dbg_in),
      .cpu_en(s_cpu_en), .pwr(s_pwr), .halted(s_halted), .halt_cause(s_halt_cause),
      .cycle_cnt(s_cycle_cnt), .debug(s_debug)
   );

   int total = 0;
   int bad   = 0;

   // ---------------- behavioural model ----------------
   // Tracks "powered", "enabled", remaining step cycles (0 = free running)
   // and the one-shot breakpoint mask, updated once per clock edge.
   bit          m_pwr, m_en, m_halted, m_mask, m_prev_cont;
   int          m_cause, m_boot_left, m_steps_left;
   longint      m_cnt;
   logic [31:0] m_dbg;

   task automatic model_step();
      bit hit, rise;
      int why, s;
      logic [31:0] nd;
      s  = int'(dbg_sel);
      nd = (s < NUM_DBG) ? ch[s] : 32'd0;
      if (!rst) begin
         m_pwr = 0; m_en = 0; m_halted = 0; m_cause = 0; m_cnt = 0; m_dbg = '0;
         m_boot_left = BOOT_CYC; m_steps_left = 0; m_mask = 0; m_prev_cont = 0;
         return;
      end
      rise = cont && !m_prev_cont;
      if (!m_pwr) begin
         m_boot_left--;
         if (m_boot_left == 0) begin
            m_pwr = 1; m_en = 1;
         end
      end else if (m_en) begin
         if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
         hit    = bp_en && (pc == bp_addr) && !m_mask;
         m_mask = 0;
         if (halt_req)               why = 1;
         else if (hit)               why = 2;
         else if (m_steps_left == 1) why = 3;
         else                        why = 0;
         if (why != 0) begin
            m_en = 0; m_halted = 1; m_cause = why; m_steps_left = 0;
         end else if (m_steps_left > 1) begin
            m_steps_left--;
         end
      end else begin
         if (rise) begin
            m_en = 1; m_halted = 0; m_cause = 0; m_mask = 1;
         end else if (step_req && step_count != 0) begin
            m_en = 1; m_halted = 0; m_steps_left = int'(step_count); m_mask = 1;
         end
      end
      m_prev_cont = cont;
      m_dbg = nd;
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cont = 0; step_req = 0; step_count = '0; bp_en = 0; bp_addr = '0;
      pc = '0; halt_req = 0; dbg_sel = '0;
      ch[0] = 32'hA; ch[1] = 32'hB; ch[2] = 32'hC;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      int edges;
      rst = 0;
      tick(); tick();
      total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL reset_cpu_en got=%0b exp=0", cpu_en); end
      total++; if (pwr !== 1'b0) begin bad++; $display("FAIL reset_pwr got=%0b exp=0", pwr); end
      total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%0b exp=0", halted); end
      total++; if (halt_cause !== 2'd0) begin bad++; $display("FAIL reset_cause got=%0d exp=0", halt_cause); end
      total++; if (cycle_cnt !== '0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cycle_cnt); end
      total++; if (debug !== '0) begin bad++; $display("FAIL reset_debug got=%0h exp=0", debug); end
      rst = 1;
      edges = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (pwr === 1'b1) begin edges = i; break; end
      end
      total++; if (edges != BOOT_CYC) begin bad++; $display("FAIL boot_len got=%0d exp=%0d", edges, BOOT_CYC); end
      total++; if (cpu_en !== 1'b1) begin bad++; $display("FAIL boot_exit_en got=%0b exp=1", cpu_en); end
   endtask

   task automatic test_halt_cont();
      int resumes;
      bit was_halted;
      // Reset was released BOOT_CYC edges ago; run on to cycle 20.
      for (int i = BOOT_CYC + 1; i < 20; i++) tick();
      halt_req = 1; tick(); halt_req = 0;
      total++; if (halted !== 1'b1 || cpu_en !== 1'b0) begin bad++; $display("FAIL halt_insn halted=%0b en=%0b exp=1/0", halted, cpu_en); end
      total++; if (halt_cause !== 2'd1) begin bad++; $display("FAIL halt_insn_cause got=%0d exp=1", halt_cause); end
      // Enabled from edge BOOT_CYC+1 through edge 20 inclusive.
      total++; if (cycle_cnt !== 32'(20 - BOOT_CYC)) begin bad++; $display("FAIL halt_cnt got=%0d exp=%0d", cycle_cnt, 20 - BOOT_CYC); end
      for (int i = 0; i < 5; i++) tick();
      total++; if (cycle_cnt !== 32'(20 - BOOT_CYC)) begin bad++; $display("FAIL halt_cnt_frozen got=%0d exp=%0d", cycle_cnt, 20 - BOOT_CYC); end
      // Hold cont for 10 cycles; halt again midway so a second resume would show.
      resumes = 0; was_halted = 1;
      cont = 1;
      for (int i = 0; i < 10; i++) begin
         halt_req = (i == 4);
         tick();
         if (was_halted && halted === 1'b0) resumes++;
         was_halted = (halted === 1'b1);
      end
      halt_req = 0; cont = 0;
      total++; if (resumes != 1) begin bad++; $display("FAIL cont_once got=%0d exp=1", resumes); end
      total++; if (halted !== 1'b1) begin bad++; $display("FAIL cont_rehalt got=%0b exp=1", halted); end
   endtask

   task automatic test_step();
      int n;
      longint base;
      base = m_cnt;
      step_count = 16'd3; step_req = 1; tick(); step_req = 0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (cpu_en === 1'b1) n++; else break;
         tick();
      end
      total++; if (n != 3) begin bad++; $display("FAIL step3_len got=%0d exp=3", n); end
      total++; if (halted !== 1'b1 || halt_cause !== 2'd3) begin bad++; $display("FAIL step3_done halted=%0b cause=%0d exp=1/3", halted, halt_cause); end
      total++; if (cycle_cnt !== 32'(base + 3)) begin bad++; $display("FAIL step3_cnt got=%0d exp=%0d", cycle_cnt, base + 3); end
      step_count = 16'd0; step_req = 1; tick(); step_req = 0;
      tick(); tick();
      total++; if (halted !== 1'b1 || cpu_en !== 1'b0) begin bad++; $display("FAIL step0_ignored halted=%0b en=%0b exp=1/0", halted, cpu_en); end
   endtask

   task automatic test_breakpoint();
      bp_en = 1; bp_addr = 32'h40; pc = 32'h30;
      cont = 1; tick(); cont = 0;
      for (int i = 0; i < 20; i++) begin
         if (halted === 1'b1) break;
         tick();
         if (cpu_en === 1'b1) pc = pc + 4;
      end
      total++; if (halted !== 1'b1 || halt_cause !== 2'd2) begin bad++; $display("FAIL bp_hit halted=%0b cause=%0d exp=1/2", halted, halt_cause); end
      total++; if (pc !== 32'h40) begin bad++; $display("FAIL bp_pc got=%0h exp=40", pc); end
      cont = 1; tick(); cont = 0;
      tick();   // pc still 0x40 on the masked first cycle
      total++; if (cpu_en !== 1'b1 || halted !== 1'b0) begin bad++; $display("FAIL bp_mask en=%0b halted=%0b exp=1/0", cpu_en, halted); end
      pc = 32'h44; tick(); pc = 32'h48; tick();
      total++; if (cpu_en !== 1'b1) begin bad++; $display("FAIL bp_run_on got=%0b exp=1", cpu_en); end
      pc = 32'h40; tick();
      total++; if (halted !== 1'b1 || halt_cause !== 2'd2) begin bad++; $display("FAIL bp_rehit halted=%0b cause=%0d exp=1/2", halted, halt_cause); end
      // halt_req and breakpoint on the same edge: halt instruction wins.
      pc = 32'h3C; cont = 1; tick(); cont = 0; tick();
      pc = 32'h40; halt_req = 1; tick(); halt_req = 0;
      total++; if (halted !== 1'b1 || halt_cause !== 2'd1) begin bad++; $display("FAIL bp_vs_halt halted=%0b cause=%0d exp=1/1", halted, halt_cause); end
      bp_en = 0;
   endtask

   task automatic test_reset_mid_step();
      int halts;
      step_count = 16'd100; step_req = 1; tick(); step_req = 0;
      for (int i = 0; i < 10; i++) tick();
      total++; if (cpu_en !== 1'b1) begin bad++; $display("FAIL midstep_en got=%0b exp=1", cpu_en); end
      rst = 0; tick();
      total++; if ({cpu_en, pwr, halted, halt_cause} !== 5'b0 || cycle_cnt !== '0 || debug !== '0)
         begin bad++; $display("FAIL midstep_reset en=%0b pwr=%0b halted=%0b cause=%0d cnt=%0d dbg=%0h exp=all 0", cpu_en, pwr, halted, halt_cause, cycle_cnt, debug); end
      rst = 1;
      for (int i = 0; i < BOOT_CYC; i++) tick();
      for (int i = 0; i < 10; i++) tick();
      total++; if (s_cycle_cnt !== 4'd10) begin bad++; $display("FAIL sat_pre got=%0d exp=10", s_cycle_cnt); end
      halts = 0;
      for (int i = 0; i < 140; i++) begin
         tick();
         if (halted === 1'b1) halts++;
      end
      total++; if (halts != 0 || cpu_en !== 1'b1) begin bad++; $display("FAIL no_step_resume halts=%0d en=%0b exp=0/1", halts, cpu_en); end
      total++; if (s_cycle_cnt !== 4'd15) begin bad++; $display("FAIL sat_cnt got=%0d exp=15", s_cycle_cnt); end
      total++; if (cycle_cnt !== 32'd150) begin bad++; $display("FAIL wide_cnt got=%0d exp=150", cycle_cnt); end
   endtask

   task automatic test_dbg();
      logic [31:0] exp_tbl [0:3];
      logic [31:0] prev;
      exp_tbl[0] = 32'hA; exp_tbl[1] = 32'hB; exp_tbl[2] = 32'hC; exp_tbl[3] = 32'h0;
      ch[0] = 32'hA; ch[1] = 32'hB; ch[2] = 32'hC;
      dbg_sel = 2'd3; tick(); tick();
      prev = 32'h0;
      for (int s = 0; s < 4; s++) begin
         dbg_sel = 2'(s);
         #1;
         total++; if (debug !== prev) begin bad++; $display("FAIL dbg_late sel=%0d got=%0h exp=%0h", s, debug, prev); end
         tick();
         total++; if (debug !== exp_tbl[s]) begin bad++; $display("FAIL dbg_sel sel=%0d got=%0h exp=%0h", s, debug, exp_tbl[s]); end
         prev = exp_tbl[s];
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 1500; c++) begin
         rst        = ($urandom_range(0, 199) != 0);
         cont       = ($urandom_range(0, 5) == 0);
         halt_req   = ($urandom_range(0, 24) == 0);
         step_req   = ($urandom_range(0, 7) == 0);
         step_count = 16'($urandom_range(0, 6));
         bp_en      = ($urandom_range(0, 1) == 1);
         bp_addr    = 32'h40;
         pc         = 32'(32'h3C + 4 * $urandom_range(0, 2));
         dbg_sel    = 2'($urandom_range(0, 3));
         ch[$urandom_range(0, 2)] = $urandom;
         tick();
         total++; if (cpu_en !== m_en) begin bad++; $display("FAIL rnd_en c=%0d got=%0b exp=%0b", c, cpu_en, m_en); end
         total++; if (pwr !== m_pwr) begin bad++; $display("FAIL rnd_pwr c=%0d got=%0b exp=%0b", c, pwr, m_pwr); end
         total++; if (halted !== m_halted) begin bad++; $display("FAIL rnd_halted c=%0d got=%0b exp=%0b", c, halted, m_halted); end
         total++; if (halt_cause !== 2'(m_cause)) begin bad++; $display("FAIL rnd_cause c=%0d got=%0d exp=%0d", c, halt_cause, m_cause); end
         total++; if (cycle_cnt !== 32'(m_cnt)) begin bad++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, cycle_cnt, m_cnt); end
         total++; if (s_cycle_cnt !== 4'((m_cnt > 15) ? 15 : m_cnt)) begin bad++; $display("FAIL rnd_sat c=%0d got=%0d exp=%0d", c, s_cycle_cnt, (m_cnt > 15) ? 15 : m_cnt); end
         total++; if (debug !== m_dbg) begin bad++; $display("FAIL rnd_dbg c=%0d got=%0h exp=%0h", c, debug, m_dbg); end
      end
      rst = 1;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst = 0;
      idle_inputs();
      test_reset();
      test_halt_cont();
      test_step();
      test_breakpoint();
      test_reset_mid_step();
      test_dbg();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Parametrised run/halt controller between the board-level control inputs and the CPU core. It gates the core through a clock-enable and handles halt instructions, continue, N-cycle single-step and a PC breakpoint. It also keeps a saturating enabled-cycle counter and drives a registered multi-channel debug mux. It supersedes the fixed clk/rst/continue/halted control scheme with configurable widths, step counts and debug channel count.

## Interface
- ADDR_W, 32, PC / breakpoint address width
- DATA_W, 32, debug channel width
- NUM_DBG, 4, number of debug channels (≥1)
- STEP_W, 16, step-count width
- CNT_W, 32, cycle-counter width
- BOOT_CYC, 4, cycles held in BOOT after reset (≥1)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-low
- cont  in  1  continue request, level input, rising-edge detected internally
- step_req  in  1  single-cycle step request pulse
- step_count  in  STEP_W  number of enabled cycles per step
- bp_en  in  1  breakpoint enable
- bp_addr  in  ADDR_W  breakpoint PC
- pc  in  ADDR_W  current PC from core
- halt_req  in  1  core executed a halt instruction
- dbg_sel  in  $clog2(NUM_DBG) or 1  debug channel select
- dbg_in  in  NUM_DBG*DATA_W  flattened debug channels; channel i is dbg_in[i*DATA_W +: DATA_W]
- cpu_en  out  1  core clock-enable
- pwr  out  1  high in every state except BOOT
- halted  out  1  high in HALT
- halt_cause  out  2  0 none, 1 halt instruction, 2 breakpoint, 3 step done
- cycle_cnt  out  CNT_W  count of enabled cycles
- debug  out  DATA_W  selected debug channel, registered

## Operation
- States: BOOT, RUN, STEP, HALT. All outputs are registered.
- Reset (rst=0 at an edge) values:
  - state=BOOT, cpu_en=0, pwr=0, halted=0, halt_cause=0, cycle_cnt=0, debug=0.
  - The cont edge-detect register and the step counter are cleared.
- Reset taken mid-RUN, mid-STEP or in HALT: the same values apply after that edge, with no residual step count.
- BOOT: hold for BOOT_CYC cycles, then go to RUN with cpu_en=1 and pwr=1.
- RUN: cpu_en=1. Exits, in priority order:
  - halt_req → HALT, cause=1.
  - Breakpoint hit (bp_en && pc==bp_addr and not masked) → HALT, cause=2.
- HALT: cpu_en=0, halted=1. Inputs, in priority order:
  - cont rising edge → RUN, cause cleared to 0.
  - Otherwise step_req with step_count≠0 → STEP, counter loaded with step_count.
  - step_req with step_count=0 is ignored.
  - halt_req in HALT is ignored.
- Breakpoint mask: on entering RUN or STEP from HALT, the breakpoint is masked for the first enabled cycle. This lets the core execute past the PC it stopped on.
- STEP: cpu_en=1; the counter decrements each cycle. Exits, in priority order:
  - halt_req → HALT, cause=1.
  - Breakpoint hit → HALT, cause=2.
  - Counter reaching 1 at an edge → HALT, cause=3.
- cycle_cnt increments on every cycle with cpu_en=1 and saturates at all-ones (no wrap).
- debug is registered from channel dbg_sel. If dbg_sel ≥ NUM_DBG, debug=0.

## Timing
- Requests sampled at edge k take effect in the cycle after edge k:
  - halt_req sampled with cpu_en=1 at edge k gives cpu_en=0 and halted=1 after edge k.
  - The core therefore completes exactly the cycle in which it raised halt_req.
- cont edge detection: a rising edge is cont=1 at edge k with cont=0 at edge k-1. Holding cont high gives one resume only.
- Step length: a step of N yields exactly N consecutive cpu_en=1 cycles, then halted=1.
- pwr rises on the same edge that leaves BOOT, BOOT_CYC edges after reset release.
- debug latency is 1 cycle from a dbg_sel or dbg_in change.
- Simultaneous halt_req and breakpoint hit: cause=1.

## Structure
- Package cpu_run_ctrl_pkg holds:
  - the state enum (BOOT, RUN, STEP, HALT);
  - the halt_cause enum (CAUSE_NONE, CAUSE_HALT, CAUSE_BP, CAUSE_STEP).
- Sub-module dbg_mux holds the parametrised registered NUM_DBG:1 selector with out-of-range zeroing. The FSM and the counters stay in cpu_run_ctrl.

## Test plan
- Reset release, then halt_req pulsed at cycle 20:
  - pwr=1 after BOOT_CYC=4 cycles;
  - halted=1 with cause=1 on the next cycle;
  - cycle_cnt frozen at its value;
  - cont held high for 10 cycles resumes exactly once.
- In HALT, step_req with step_count=3: exactly 3 cpu_en cycles, then halted=1 with cause=3, and cycle_cnt advances by 3. A second step_req with step_count=0 leaves the block in HALT.
- bp_en=1, bp_addr=0x40, pc reaches 0x40:
  - halt with cause=2;
  - cont with pc still 0x40 resumes and does not re-halt on the first cycle;
  - re-halts when pc returns to 0x40 later.
- Synchronous rst=0 asserted during a step of 100 cycles: after the edge all outputs hold their reset values, and after release there is no resumption of the step.
- With CNT_W=4, run for 20 cycles: cycle_cnt stops at 15.
- With NUM_DBG=3, dbg_in channels 0xA, 0xB, 0xC and dbg_sel sweeping 0..3: debug is 0xA, 0xB, 0xC, 0, each one cycle late.
